// File: rtl/jtag_dtm_if.sv
// DMI request/response bus between the JTAG DTM (master) and the debug module (slave).
interface jtag_dtm_if;
  logic        dmi_valid;
  logic        dmi_ready;
  logic        dmi_write;
  logic [6:0]  dmi_addr;
  logic [31:0] dmi_wdata;
  logic [31:0] dmi_rdata;

  modport master (
    output dmi_valid, dmi_write, dmi_addr, dmi_wdata,
    input  dmi_ready, dmi_rdata
  );

  modport slave (
    input  dmi_valid, dmi_write, dmi_addr, dmi_wdata,
    output dmi_ready, dmi_rdata
  );
endinterface

// File: rtl/jtag_dtm.sv
// RISC-V style JTAG debug transport module: oversampled TAP, IR/DR chains and a DMI request port,
// entirely in the clk domain.
module jtag_dtm #(
  parameter logic [31:0] IDCODE = 32'h1000_0001,
  parameter int          SYNC   = 2
) (
  input  logic      clk,
  input  logic      resetn,
  input  logic      tck,
  input  logic      tms,
  input  logic      tdi,
  output logic      tdo,
  jtag_dtm_if.master dmi
);

  typedef enum logic [3:0] {
    TLR, RTI,
    SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
  } tap_e;

  localparam logic [1:0] SEL_BYP = 2'd0, SEL_ID = 2'd1, SEL_CS = 2'd2, SEL_DMI = 2'd3;

  logic [SYNC-1:0] tck_sync_q, tck_sync_d, tms_sync_q, tms_sync_d, tdi_sync_q, tdi_sync_d;
  logic            tck_prev_q, tck_prev_d;
  tap_e            tap_q, tap_d, tap_next;
  logic [4:0]      ir_q, ir_d, ir_shift_q, ir_shift_d;
  logic [40:0]     dr_shift_q, dr_shift_d;
  logic            tdo_q, tdo_d;
  logic            dmi_valid_q, dmi_valid_d, dmi_write_q, dmi_write_d;
  logic [6:0]      dmi_addr_q, dmi_addr_d;
  logic [31:0]     dmi_wdata_q, dmi_wdata_d, last_rdata_q, last_rdata_d;
  logic [1:0]      dmistat_q, dmistat_d;

  logic tck_s, tms_s, tdi_s, tck_rise, tck_fall;
  logic capture_dr, shift_dr, update_dr, capture_ir, shift_ir, update_ir, in_tlr, in_shift_ir, in_shift_dr;
  logic [1:0]  dr_sel, dmi_status, dmi_op;
  logic [31:0] dtmcs_cap;

  always_comb begin
    tck_sync_d = {tck_sync_q[SYNC-2:0], tck};
    tms_sync_d = {tms_sync_q[SYNC-2:0], tms};
    tdi_sync_d = {tdi_sync_q[SYNC-2:0], tdi};
    tck_s      = tck_sync_q[SYNC-1];
    tms_s      = tms_sync_q[SYNC-1];
    tdi_s      = tdi_sync_q[SYNC-1];
    tck_prev_d = tck_s;
    tck_rise   = tck_s & ~tck_prev_q;
    tck_fall   = ~tck_s & tck_prev_q;
  end

  // TAP state register: advances only on a synchronized rising tck.
  always_ff @(posedge clk) begin
    if (!resetn) tap_q <= TLR;
    else         tap_q <= tap_d;
  end

  always_comb begin
    tap_next = tap_q;
    case (tap_q)
      TLR:     tap_next = tms_s ? TLR    : RTI;
      RTI:     tap_next = tms_s ? SEL_DR : RTI;
      SEL_DR:  tap_next = tms_s ? SEL_IR : CAP_DR;
      CAP_DR:  tap_next = tms_s ? EX1_DR : SH_DR;
      SH_DR:   tap_next = tms_s ? EX1_DR : SH_DR;
      EX1_DR:  tap_next = tms_s ? UPD_DR : PAU_DR;
      PAU_DR:  tap_next = tms_s ? EX2_DR : PAU_DR;
      EX2_DR:  tap_next = tms_s ? UPD_DR : SH_DR;
      UPD_DR:  tap_next = tms_s ? SEL_DR : RTI;
      SEL_IR:  tap_next = tms_s ? TLR    : CAP_IR;
      CAP_IR:  tap_next = tms_s ? EX1_IR : SH_IR;
      SH_IR:   tap_next = tms_s ? EX1_IR : SH_IR;
      EX1_IR:  tap_next = tms_s ? UPD_IR : PAU_IR;
      PAU_IR:  tap_next = tms_s ? EX2_IR : PAU_IR;
      EX2_IR:  tap_next = tms_s ? UPD_IR : SH_IR;
      UPD_IR:  tap_next = tms_s ? SEL_DR : RTI;
      default: tap_next = TLR;
    endcase
    tap_d = tck_rise ? tap_next : tap_q;
  end

  // Capture/shift act on the rising edge that leaves the state; update acts on the falling edge inside it.
  always_comb begin
    in_tlr      = (tap_q == TLR);
    in_shift_ir = (tap_q == SH_IR);
    in_shift_dr = (tap_q == SH_DR);
    capture_dr  = tck_rise && (tap_q == CAP_DR);
    shift_dr    = tck_rise && in_shift_dr;
    capture_ir  = tck_rise && (tap_q == CAP_IR);
    shift_ir    = tck_rise && in_shift_ir;
    update_dr   = tck_fall && (tap_q == UPD_DR);
    update_ir   = tck_fall && (tap_q == UPD_IR);
  end

  always_comb begin
    case (ir_q)
      5'h01:   dr_sel = SEL_ID;
      5'h10:   dr_sel = SEL_CS;
      5'h11:   dr_sel = SEL_DMI;
      default: dr_sel = SEL_BYP;
    endcase
    dmi_status = (dmi_valid_q || dmistat_q == 2'd3) ? 2'd3 : 2'd0;
    dtmcs_cap  = {14'b0, 1'b0, 1'b0, 1'b0, 3'd1, dmistat_q, 6'd7, 4'd1};
    dmi_op     = dr_shift_q[1:0];
  end

  always_comb begin
    ir_shift_d = ir_shift_q;
    if (capture_ir)    ir_shift_d = 5'b00001;
    else if (shift_ir) ir_shift_d = {tdi_s, ir_shift_q[4:1]};
    ir_d = ir_q;
    if (in_tlr)         ir_d = 5'h01;
    else if (update_ir) ir_d = ir_shift_q;

    // One shared chain; the selected register's MSB is where tdi enters.
    dr_shift_d = dr_shift_q;
    if (capture_dr) begin
      case (dr_sel)
        SEL_ID:  dr_shift_d = {9'b0, IDCODE};
        SEL_CS:  dr_shift_d = {9'b0, dtmcs_cap};
        SEL_DMI: dr_shift_d = {dmi_addr_q, last_rdata_q, dmi_status};
        default: dr_shift_d = 41'b0;
      endcase
    end else if (shift_dr) begin
      case (dr_sel)
        SEL_ID, SEL_CS: dr_shift_d = {9'b0, tdi_s, dr_shift_q[31:1]};
        SEL_DMI:        dr_shift_d = {tdi_s, dr_shift_q[40:1]};
        default:        dr_shift_d = {40'b0, tdi_s};
      endcase
    end

    tdo_d = tdo_q;
    if (tck_fall) begin
      if (in_shift_ir)      tdo_d = ir_shift_q[0];
      else if (in_shift_dr) tdo_d = dr_shift_q[0];
      else                  tdo_d = 1'b0;
    end
  end

  always_comb begin
    dmi_valid_d  = dmi_valid_q;
    dmi_write_d  = dmi_write_q;
    dmi_addr_d   = dmi_addr_q;
    dmi_wdata_d  = dmi_wdata_q;
    last_rdata_d = last_rdata_q;
    dmistat_d    = dmistat_q;
    if (dmi_valid_q && dmi.dmi_ready) begin
      dmi_valid_d = 1'b0;
      if (!dmi_write_q) last_rdata_d = dmi.dmi_rdata;
    end
    if (update_dr && dr_sel == SEL_DMI && (dmi_op == 2'd1 || dmi_op == 2'd2)) begin
      if (dmi_valid_q || dmistat_q == 2'd3) begin
        dmistat_d = 2'd3;
      end else begin
        dmi_valid_d = 1'b1;
        dmi_addr_d  = dr_shift_q[40:34];
        dmi_wdata_d = dr_shift_q[33:2];
        dmi_write_d = (dmi_op == 2'd2);
      end
    end
    if (update_dr && dr_sel == SEL_CS) begin
      if (dr_shift_q[16] || dr_shift_q[17]) dmistat_d = 2'd0;
      if (dr_shift_q[17])                   dmi_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      tck_sync_q   <= '0;
      tms_sync_q   <= '0;
      tdi_sync_q   <= '0;
      tck_prev_q   <= 1'b0;
      ir_q         <= 5'h01;
      ir_shift_q   <= 5'b0;
      dr_shift_q   <= 41'b0;
      tdo_q        <= 1'b0;
      dmi_valid_q  <= 1'b0;
      dmi_write_q  <= 1'b0;
      dmi_addr_q   <= 7'b0;
      dmi_wdata_q  <= 32'b0;
      last_rdata_q <= 32'b0;
      dmistat_q    <= 2'b0;
    end else begin
      tck_sync_q   <= tck_sync_d;
      tms_sync_q   <= tms_sync_d;
      tdi_sync_q   <= tdi_sync_d;
      tck_prev_q   <= tck_prev_d;
      ir_q         <= ir_d;
      ir_shift_q   <= ir_shift_d;
      dr_shift_q   <= dr_shift_d;
      tdo_q        <= tdo_d;
      dmi_valid_q  <= dmi_valid_d;
      dmi_write_q  <= dmi_write_d;
      dmi_addr_q   <= dmi_addr_d;
      dmi_wdata_q  <= dmi_wdata_d;
      last_rdata_q <= last_rdata_d;
      dmistat_q    <= dmistat_d;
    end
  end

  assign tdo           = tdo_q;
  assign dmi.dmi_valid = dmi_valid_q;
  assign dmi.dmi_write = dmi_write_q;
  assign dmi.dmi_addr  = dmi_addr_q;
  assign dmi.dmi_wdata = dmi_wdata_q;

endmodule

// File: tb/tb_jtag_dtm.sv
// Bench for jtag_dtm: table of register captures, directed DMI corner cases and a randomized
// DMI sequence checked against a transaction-level model of the DTM registers.
module tb_jtag_dtm;
  logic clk = 1'b0, resetn = 1'b0, tck = 1'b0, tms = 1'b0, tdi = 1'b0;
  logic tdo;
  int   errors = 0, checks = 0;

  jtag_dtm_if dmi_bus ();

  jtag_dtm #(.IDCODE(32'h1000_0001), .SYNC(2)) dut (
    .clk(clk), .resetn(resetn), .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo), .dmi(dmi_bus.master)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Transaction-level model of the DTM-visible state.
  logic [6:0]  m_addr;
  logic [31:0] m_wdata, m_rdata;
  logic        m_write, m_busy;
  logic [1:0]  m_stat;

  task automatic model_reset();
    m_addr = 0; m_wdata = 0; m_rdata = 0; m_write = 0; m_busy = 0; m_stat = 0;
  endtask

  function automatic logic [40:0] m_dmi_cap();
    return {m_addr, m_rdata, (m_busy || m_stat == 2'd3) ? 2'd3 : 2'd0};
  endfunction

  function automatic logic [40:0] m_dtmcs_cap();
    return {9'b0, 32'h0000_1071 | (32'(m_stat) << 10)};
  endfunction

  task automatic m_dmi_update(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op);
    if (op == 2'd1 || op == 2'd2) begin
      if (m_busy || m_stat == 2'd3) m_stat = 2'd3;
      else begin
        m_busy = 1; m_addr = a; m_wdata = d; m_write = (op == 2'd2);
      end
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // One tck period; returns tdo as it stood before this rising edge.
  task automatic jtck(input logic tms_v, input logic tdi_v, output logic tdo_v);
    tdo_v = tdo;
    tms = tms_v; tdi = tdi_v;
    #10 tck = 1'b1;
    #50 tck = 1'b0;
    #50;
  endtask

  task automatic tap_reset();
    logic b;
    for (int i = 0; i < 5; i++) jtck(1'b1, 1'b0, b);
    jtck(1'b0, 1'b0, b);
  endtask

  task automatic scan_ir(input logic [4:0] v, output logic [4:0] dout);
    logic b;
    dout = '0;
    jtck(1, 0, b); jtck(1, 0, b); jtck(0, 0, b); jtck(0, 0, b);
    for (int i = 0; i < 5; i++) begin
      jtck(i == 4, v[i], b);
      dout[i] = b;
    end
    jtck(1, 0, b); jtck(0, 0, b);
  endtask

  task automatic scan_dr(input logic [40:0] v, input int len, output logic [40:0] dout);
    logic b;
    dout = '0;
    jtck(1, 0, b); jtck(0, 0, b); jtck(0, 0, b);
    for (int i = 0; i < len; i++) begin
      jtck(i == len - 1, v[i], b);
      dout[i] = b;
    end
    jtck(1, 0, b); jtck(0, 0, b);
  endtask

  task automatic dmi_scan(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op,
                          input string name);
    logic [40:0] cap;
    scan_dr({a, d, op}, 41, cap);
    check(name, cap, m_dmi_cap());
    m_dmi_update(a, d, op);
  endtask

  task automatic set_ir(input logic [4:0] v);
    logic [4:0] ign;
    scan_ir(v, ign);
  endtask

  task automatic handshake(input logic [31:0] rd, input int stall);
    int waited = 0;
    @(negedge clk);
    while (!dmi_bus.dmi_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("hs_valid", dmi_bus.dmi_valid, 1);
    check("hs_fields", {dmi_bus.dmi_write, dmi_bus.dmi_addr, dmi_bus.dmi_wdata},
          {m_write, m_addr, m_wdata});
    for (int i = 0; i < stall; i++) begin
      dmi_bus.dmi_ready = 1'b0;
      @(negedge clk);
      check("hs_stall_hold", {dmi_bus.dmi_valid, dmi_bus.dmi_write, dmi_bus.dmi_addr, dmi_bus.dmi_wdata},
            {1'b1, m_write, m_addr, m_wdata});
    end
    dmi_bus.dmi_ready = 1'b1;
    dmi_bus.dmi_rdata = rd;
    @(negedge clk);
    dmi_bus.dmi_ready = 1'b0;
    dmi_bus.dmi_rdata = $urandom;
    check("hs_drop", dmi_bus.dmi_valid, 0);
    m_busy = 0;
    if (!m_write) m_rdata = rd;
  endtask

  typedef struct {
    string       name;
    logic [4:0]  ir;
    int          len;
    logic [40:0] exp;
  } vec_t;

  initial begin
    vec_t        vecs[5];
    logic [4:0]  irout;
    logic [40:0] dout;
    logic [7:0]  pat;
    logic [1:0]  op;

    dmi_bus.dmi_ready = 1'b0;
    dmi_bus.dmi_rdata = 32'h0;
    model_reset();

    vecs[0] = '{"idcode",   5'h01, 32, 41'h0_1000_0001};
    vecs[1] = '{"dtmcs",    5'h10, 32, 41'h0_0000_1071};
    vecs[2] = '{"bypass00", 5'h00, 1,  41'h0};
    vecs[3] = '{"bypass1f", 5'h1F, 1,  41'h0};
    vecs[4] = '{"bypass05", 5'h05, 1,  41'h0};

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_outputs", {tdo, dmi_bus.dmi_valid, dmi_bus.dmi_write, dmi_bus.dmi_addr, dmi_bus.dmi_wdata}, 0);
    resetn = 1'b1;

    // Straight out of reset IR selects IDCODE.
    tap_reset();
    scan_dr(41'h0, 32, dout);
    check("rst_idcode", dout, 41'h0_1000_0001);

    foreach (vecs[i]) begin
      scan_ir(vecs[i].ir, irout);
      check("ir_capture", irout, 5'b00001);
      scan_dr({9'b0, $urandom & 32'hFFFC_FFFF}, vecs[i].len, dout);
      check(vecs[i].name, dout, vecs[i].exp);
    end

    set_ir(5'h1F);
    pat = 8'($urandom);
    scan_dr({33'b0, pat}, 8, dout);
    check("bypass_delay", dout, {33'b0, pat[6:0], 1'b0});

    // Write with one stall cycle, then a read returning fixed data.
    set_ir(5'h11);
    dmi_scan(7'h04, 32'hDEAD_BEEF, 2'd2, "wr_cap");
    handshake(32'hFFFF_0000, 1);
    dmi_scan(7'h04, 32'h0, 2'd1, "rd_cap");
    handshake(32'h1234_5678, 2);
    scan_dr(41'h0, 41, dout);
    check("rd_result", {dout[33:2], dout[1:0]}, {32'h1234_5678, 2'd0});
    check("rd_result_full", dout, m_dmi_cap());

    // Busy collision: second update is dropped and dmistat goes sticky.
    dmi_scan(7'h05, 32'hA5A5_A5A5, 2'd2, "busy_first");
    dmi_scan(7'h06, 32'h0000_1111, 2'd1, "busy_second");
    check("busy_addr_kept", dmi_bus.dmi_addr, 7'h05);
    handshake(32'h0, 0);
    dmi_scan(7'h0, 32'h0, 2'd0, "busy_sticky");
    repeat (3) @(negedge clk);
    check("busy_no_reissue", dmi_bus.dmi_valid, 0);
    set_ir(5'h10);
    scan_dr(41'h1_0000, 32, dout);
    check("dtmcs_busy", dout, m_dtmcs_cap());
    m_stat = 0;
    scan_dr(41'h0, 32, dout);
    check("dtmcs_cleared", dout, m_dtmcs_cap());
    set_ir(5'h11);
    dmi_scan(7'h0, 32'h0, 2'd0, "status_cleared");

    // dmihardreset abandons the outstanding request.
    dmi_scan(7'h22, 32'h0BAD_F00D, 2'd2, "hard_issue");
    set_ir(5'h10);
    scan_dr(41'h2_0000, 32, dout);
    check("hard_dtmcs", dout, m_dtmcs_cap());
    m_busy = 0; m_stat = 0;
    @(negedge clk);
    check("hard_valid_drop", dmi_bus.dmi_valid, 0);

    // TMS reset leaves an outstanding request alone and resets IR.
    set_ir(5'h11);
    dmi_scan(7'h33, 32'hCAFE_0001, 2'd1, "tlr_issue");
    tap_reset();
    check("tlr_valid_kept", dmi_bus.dmi_valid, 1);
    scan_dr(41'h0, 32, dout);
    check("tlr_idcode", dout, 41'h0_1000_0001);
    handshake(32'h5555_AAAA, 1);

    set_ir(5'h11);
    for (int it = 0; it < 12; it++) begin
      op = 2'($urandom_range(0, 3));
      dmi_scan(7'($urandom), $urandom, op, "rnd_cap");
      check("rnd_valid", dmi_bus.dmi_valid, m_busy);
      if (m_busy) begin
        if ($urandom_range(0, 1) == 1)
          dmi_scan(7'($urandom), $urandom, 2'($urandom_range(1, 2)), "rnd_busy_cap");
        handshake($urandom, $urandom_range(0, 3));
      end
      if (m_stat == 2'd3) begin
        set_ir(5'h10);
        scan_dr(41'h1_0000, 32, dout);
        check("rnd_dtmcs", dout, m_dtmcs_cap());
        m_stat = 0;
        set_ir(5'h11);
      end
    end

    // System reset in the middle of a request with sticky status set.
    dmi_scan(7'h44, 32'h7777_7777, 2'd2, "srst_issue");
    dmi_scan(7'h45, 32'h0, 2'd1, "srst_busy");
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    check("srst_valid_drop", dmi_bus.dmi_valid, 0);
    resetn = 1'b1;
    model_reset();
    tap_reset();
    scan_dr(41'h0, 32, dout);
    check("srst_ir_idcode", dout, 41'h0_1000_0001);
    set_ir(5'h10);
    scan_dr(41'h0, 32, dout);
    check("srst_dmistat", dout, m_dtmcs_cap());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
